// File: rtl/fp_alu_pkg.sv
// Shared types for the FP32 byte-serial ALU bridge.
// Holds the bridge FSM states and the frame/result byte counts.
package fp_alu_pkg;

  localparam int FRAME_BYTES  = 8;
  localparam int RESULT_BYTES = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_SEND,
    S_WAIT_DONE,
    S_RECV,
    S_RESP
  } state_e;

endpackage

// File: rtl/fp_serial_bridge.sv
// Bridges a 32-bit FP add/sub request onto a byte-serial ALU.
// Ports: req_* upstream handshake, rsp_* downstream handshake,
//   alu_* byte-serial ALU link; clk, rst_n (async, active-low).
module fp_serial_bridge
  import fp_alu_pkg::*;
#(
  parameter int TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic        req_op,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_timeout,
  output logic        alu_start,
  output logic        alu_opcode,
  output logic [7:0]  alu_in,
  input  logic        alu_done,
  input  logic [7:0]  alu_out
);

  // One counter serves SEND bytes, WAIT_DONE cycles and RECV bytes.
  localparam int CMAX =
    (TIMEOUT > FRAME_BYTES) ? TIMEOUT : FRAME_BYTES;
  localparam int CW = $clog2(CMAX);

  localparam logic [CW-1:0] LAST_TX = CW'(FRAME_BYTES - 1);
  localparam logic [CW-1:0] LAST_RX = CW'(RESULT_BYTES - 1);
  localparam logic [CW-1:0] LAST_TO = CW'(TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   a_q, a_d;
  logic [31:0]   b_q, b_d;
  logic          op_q, op_d;
  logic [31:0]   res_q, res_d;
  logic          to_q, to_d;

  logic [63:0]   frame;
  logic [5:0]    tx_idx;
  logic [4:0]    rx_idx;

  // A occupies the low four frame bytes, B the high four.
  assign frame  = {b_q, a_q};
  assign tx_idx = {cnt_q[2:0], 3'b000};
  assign rx_idx = {cnt_q[1:0], 3'b000};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= 1'b0;
      res_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
      to_q    <= to_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    res_d       = res_q;
    to_d        = to_q;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    rsp_result  = '0;
    rsp_timeout = 1'b0;
    alu_start   = 1'b0;
    alu_opcode  = 1'b0;
    alu_in      = '0;

    unique case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          a_d     = req_a;
          b_d     = req_b;
          op_d    = req_op;
          res_d   = '0;
          to_d    = 1'b0;
          cnt_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        alu_start  = 1'b1;
        alu_opcode = op_q;
        cnt_d      = '0;
        state_d    = S_SEND;
      end
      S_SEND: begin
        alu_opcode = op_q;
        alu_in     = frame[tx_idx +: 8];
        if (cnt_q == LAST_TX) begin
          cnt_d   = '0;
          state_d = S_WAIT_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT_DONE: begin
        alu_opcode = op_q;
        if (alu_done) begin
          cnt_d   = '0;
          state_d = S_RECV;
        end else if (cnt_q == LAST_TO) begin
          to_d    = 1'b1;
          res_d   = '0;
          cnt_d   = '0;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RECV: begin
        alu_opcode          = op_q;
        res_d[rx_idx +: 8]  = alu_out;
        if (cnt_q == LAST_RX) begin
          cnt_d   = '0;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        rsp_valid   = 1'b1;
        rsp_result  = res_q;
        rsp_timeout = to_q;
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_fp_serial_bridge.sv
// Scoreboard bench for fp_serial_bridge with a byte-serial ALU model.
// Stimulus pushes expectations; a monitor pops them on rsp_valid.
module tb_fp_serial_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        req_op;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_timeout;
  logic        alu_start;
  logic        alu_opcode;
  logic [7:0]  alu_in;
  logic        alu_done;
  logic [7:0]  alu_out;

  always #5 clk = ~clk;

  fp_serial_bridge #(.TIMEOUT(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_op      (req_op),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_result  (rsp_result),
    .rsp_timeout (rsp_timeout),
    .alu_start   (alu_start),
    .alu_opcode  (alu_opcode),
    .alu_in      (alu_in),
    .alu_done    (alu_done),
    .alu_out     (alu_out)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] res;
    logic        to;
    int          acc;
    int          lat;
    int          hold;
  } exp_t;

  exp_t sbq[$];

  // Pending transaction info for the ALU model, latched at alu_start.
  logic [31:0] pa, pb, pres;
  logic        pop, pnd, pspur;
  logic [31:0] ca, cb, cres;
  logic        cop, cnd, cspur;
  int          ph = 0;

  // ALU model: ph counts cycles since the alu_start cycle.
  initial begin
    logic [63:0] fr;
    alu_done = 1'b0;
    alu_out  = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        ph       = 0;
        alu_done = 1'b0;
        alu_out  = 8'h00;
      end else if (ph == 0) begin
        if (alu_start) begin
          ca = pa; cb = pb; cres = pres;
          cop = pop; cnd = pnd; cspur = pspur;
          chk("start_opcode", alu_opcode, cop);
          ph = 1;
        end
      end else begin
        fr = {cb, ca};
        chk("start_pulse", alu_start, 0);
        if (ph <= 8)
          chk("alu_in_byte", alu_in, fr[8*(ph-1) +: 8]);
        else if (ph <= 15)
          chk("alu_in_zero", alu_in, 0);
        if (ph <= 15)
          chk("alu_opcode", alu_opcode, cop);
        alu_done = (ph == 11 && !cnd) ||
                   (ph == 4 && cspur);
        alu_out  = (ph >= 12 && ph <= 15 && !cnd) ?
                   cres[8*(ph-12) +: 8] : 8'h00;
        ph = (ph == 16) ? 0 : ph + 1;
      end
    end
  end

  // Response monitor and rsp_ready driver.
  initial begin
    exp_t cur;
    bit   first;
    int   hl;
    first = 1;
    hl    = 0;
    cur   = '{res: 0, to: 0, acc: 0, lat: -1, hold: 0};
    rsp_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        first     = 1;
        hl        = 0;
        rsp_ready = 1'b0;
      end else if (rsp_valid) begin
        if (first) begin
          if (sbq.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_rsp: got %h expected none",
                     rsp_result);
            cur = '{res: 0, to: 0, acc: 0, lat: -1, hold: 0};
          end else begin
            cur = sbq.pop_front();
            chk("rsp_result", rsp_result, cur.res);
            chk("rsp_timeout", rsp_timeout, cur.to);
            if (cur.lat >= 0)
              chk("latency", cyc - cur.acc, cur.lat);
          end
          hl    = cur.hold;
          first = 0;
        end else begin
          chk("hold_result", rsp_result, cur.res);
          chk("hold_timeout", rsp_timeout, cur.to);
          chk("hold_req_ready", req_ready, 0);
        end
        if (hl > 0) begin
          rsp_ready = 1'b0;
          hl--;
        end else begin
          rsp_ready = 1'b1;
          first     = 1;
        end
      end else begin
        rsp_ready = 1'b0;
      end
    end
  end

  // Presents a request and returns once it is accepted.
  task automatic do_req(input logic [31:0] a, input logic [31:0] b,
                        input logic op, input logic [31:0] res,
                        input logic nd, input logic spur,
                        input int lat, input int hold,
                        output int acc);
    exp_t e;
    int   w;
    req_a     = a;
    req_b     = b;
    req_op    = op;
    req_valid = 1'b1;
    w = 0;
    while (!req_ready && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    if (!req_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_wait: got busy expected ready");
      req_valid = 1'b0;
      acc = -1;
      return;
    end
    acc   = cyc;
    pa    = a;
    pb    = b;
    pres  = res;
    pop   = op;
    pnd   = nd;
    pspur = spur;
    e.res  = nd ? 32'h0 : res;
    e.to   = nd;
    e.acc  = cyc;
    e.lat  = lat;
    e.hold = hold;
    sbq.push_back(e);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((sbq.size() != 0 || rsp_valid || !req_ready) &&
           w < 200) begin
      @(posedge clk); #1;
      w++;
    end
    n_tests++;
    if (w >= 200) begin
      n_fail++;
      $display("FAIL drain: got busy expected idle");
    end
  endtask

  task automatic chk_reset_outs(string tag);
    chk({tag, "_req_ready"}, req_ready, 1);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_result"}, rsp_result, 0);
    chk({tag, "_rsp_timeout"}, rsp_timeout, 0);
    chk({tag, "_alu_start"}, alu_start, 0);
    chk({tag, "_alu_opcode"}, alu_opcode, 0);
    chk({tag, "_alu_in"}, alu_in, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc1, acc2;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_a     = '0;
    req_b     = '0;
    req_op    = 1'b0;
    pa = '0; pb = '0; pres = '0;
    pop = 1'b0; pnd = 1'b0; pspur = 1'b0;
    #2;
    chk_reset_outs("por");
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    // Add 1.0 + 2.0 = 3.0
    do_req(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000,
           1'b0, 1'b0, 17, 0, acc1);
    drain();

    // Subtract 3.0 - 1.0 = 2.0
    do_req(32'h40400000, 32'h3F800000, 1'b1, 32'h40000000,
           1'b0, 1'b0, 17, 0, acc1);
    drain();

    // Byte order, with a stray alu_done during SEND
    do_req(32'h11223344, 32'h55667788, 1'b0, 32'hCAFEF00D,
           1'b0, 1'b1, 17, 0, acc1);
    drain();

    // Timeout then a normal add
    do_req(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000,
           1'b1, 1'b0, 18, 0, acc1);
    drain();
    do_req(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000,
           1'b0, 1'b0, 17, 0, acc1);
    drain();

    // Backpressure with a second request held waiting
    do_req(32'h40000000, 32'h40000000, 1'b0, 32'h40800000,
           1'b0, 1'b0, 17, 5, acc1);
    do_req(32'h40800000, 32'h3F800000, 1'b1, 32'h40400000,
           1'b0, 1'b0, 17, 0, acc2);
    chk("bp_accept_cycle", acc2 - acc1, 23);
    drain();

    // Reset in the middle of SEND
    do_req(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000,
           1'b0, 1'b0, 17, 0, acc1);
    repeat (4) begin
      @(posedge clk); #1;
    end
    chk("rst_in_send", cyc - acc1, 5);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_outs("mid");
    sbq.delete();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    repeat (20) begin
      @(posedge clk); #1;
    end
    chk("post_rst_idle", req_ready, 1);
    do_req(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000,
           1'b0, 1'b0, 17, 0, acc1);
    drain();

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_serial_bridge.md
FP_SERIAL_BRIDGE -- requirements
Module: fp_serial_bridge

Interface
REQ-001 Parameter TIMEOUT, default 8: maximum cycles spent in WAIT_DONE before the transaction is aborted.
REQ-002 clk  in  1  clock; all logic on the rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 req_valid  in  1  upstream has a request.
REQ-005 req_ready  out  1  bridge accepts a request this cycle.
REQ-006 req_a / req_b  in  32 each  FP32 operands A and B.
REQ-007 req_op  in  1  0 = add, 1 = subtract (A-B).
REQ-008 rsp_valid  out  1  response held valid.
REQ-009 rsp_ready  in  1  downstream takes the response.
REQ-010 rsp_result  out  32  FP32 result.
REQ-011 rsp_timeout  out  1  response is an abort; rsp_result = 0.
REQ-012 alu_start  out  1  start strobe to the byte-serial ALU.
REQ-013 alu_opcode  out  1  op to the ALU.
REQ-014 alu_in  out  8  operand byte to the ALU.
REQ-015 alu_done  in  1  ALU done strobe.
REQ-016 alu_out  in  8  ALU result byte.

Function
REQ-017 The FSM SHALL have states IDLE, START, SEND, WAIT_DONE, RECV and RESP.
REQ-018 req_ready SHALL be 1 only in IDLE; the handshake req_valid&req_ready SHALL latch req_a, req_b and req_op and go to START.
REQ-019 START SHALL last one cycle with alu_start=1; alu_start SHALL be 0 in every other state.
REQ-020 SEND SHALL last exactly 8 cycles; alu_in SHALL carry A[7:0], A[15:8], A[23:16], A[31:24], B[7:0] ... B[31:24] in that order, one byte per cycle, with byte k present in SEND cycle k.
REQ-021 alu_opcode SHALL equal the latched req_op from START through RECV, and 0 in IDLE.
REQ-022 WAIT_DONE SHALL increment a cycle counter.
  - alu_done=1 -> go to RECV.
  - Counter reaches TIMEOUT without alu_done -> go to RESP with rsp_timeout=1 and rsp_result=0.
REQ-023 RECV SHALL last exactly 4 cycles, starting the cycle after alu_done was seen, and capture alu_out as result[7:0], [15:8], [23:16], [31:24] in order.
REQ-024 RESP SHALL hold rsp_valid=1 with stable rsp_result and rsp_timeout until rsp_ready=1, then return to IDLE.
REQ-025 rsp_valid SHALL be 0 in all states other than RESP.
REQ-026 Nominal latency SHALL be as follows: accept in cycle 0, alu_start in cycle 1, bytes in cycles 2-9, alu_done in cycle 12, rsp_valid first high in cycle 17.
REQ-027 alu_done seen outside WAIT_DONE SHALL be ignored.
REQ-028 A req_valid seen outside IDLE SHALL be ignored; there SHALL be no queueing.
REQ-029 A timed-out transaction SHALL NOT retry automatically.
REQ-030 alu_in SHALL be 0 outside SEND.

Reset
REQ-031 While rst_n=0, the bridge SHALL be in state IDLE.
REQ-032 While rst_n=0, all outputs SHALL be 0 except req_ready=1, and the internal operand, result and counter registers SHALL be 0.
REQ-033 A reset asserted mid-transaction SHALL abandon it immediately with no response emitted; the ALU SHALL share the same rst_n.

Structure
REQ-034 The state enum, FRAME_BYTES=8 and RESULT_BYTES=4 SHALL live in shared package fp_alu_pkg.
REQ-035 The bridge SHALL be a single module with a single FSM and a shared byte counter, and SHALL have no sub-modules.

Verification
REQ-036 Add: A=0x3F800000, B=0x40000000, op=0 -> rsp_result=0x40400000, rsp_timeout=0, with rsp_valid first high in cycle 17.
REQ-037 Subtract: A=0x40400000, B=0x3F800000, op=1 -> rsp_result=0x40000000, and alu_opcode=1 throughout cycles 1-16.
REQ-038 Byte order: A=0x11223344, B=0x55667788 -> alu_in sequence 44,33,22,11,88,77,66,55 in cycles 2-9.
REQ-039 Timeout: ALU model never raises alu_done -> rsp_valid with rsp_timeout=1 and rsp_result=0 after 8 WAIT_DONE cycles; the next request then completes normally.
REQ-040 Backpressure: rsp_ready held 0 for 5 cycles -> response stable and req_ready=0; with a second req_valid held high, that request is accepted only on the first IDLE cycle after rsp_ready.
REQ-041 Reset mid-SEND (cycle 5) -> all outputs reach reset values asynchronously, no response is produced, and a fresh add then completes correctly.
